sequence_event_logger: RTL and testbench
========================================

# sequence_event_logger

Downstream stage of the sequence detector: consumes the detector's active-high detection output and logs each new detection. For every detection it records the number of `sysClk` cycles since the previous detection into a small show-ahead FIFO, which a consumer drains with a pop handshake. It also keeps a saturating event count and a sticky overflow flag for the monitoring logic.

## Interface
Parameters:
- `GAP_WIDTH`, default 8: width of each gap entry and of the gap counter.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2, at least 2.
- `CNT_WIDTH`, default 8: width of the event counter.

Ports:
- `sysClk` input 1: system clock; everything is sampled on the rising edge.
- `resetH` input 1: reset. One clock; reset is synchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
- `detectAH` input 1: detection output of the sequence detector (its `outAH`).
- `clearH` input 1: synchronous clear of log state.
- `popH` input 1: consumer removes the head entry.
- `gapOut` output GAP_WIDTH: head FIFO entry; valid only while `gapValidH`=1; 0 when empty.
- `gapValidH` output 1: FIFO not empty.
- `fifoFullH` output 1: FIFO holds FIFO_DEPTH entries.
- `overflowH` output 1: sticky flag; at least one gap was dropped.
- `eventCount` output CNT_WIDTH: saturating count of detection events.

## Operation
- Event detection:
  - `detectD` is a register holding `detectAH` delayed by one cycle.
  - event = `detectAH` & ~`detectD`, so only the rising edge counts. A level held high for N cycles is one event.
- Gap counter `gapCnt`:
  - Increments every cycle and saturates at 2^GAP_WIDTH-1.
  - On an event cycle the current `gapCnt` is the pushed value, and `gapCnt` loads 1.
  - Result: events at cycles t and t+k push k.
- Push rules:
  - On an event with the FIFO not full, the gap is written at the tail.
  - If the FIFO is full and no pop happens that cycle, the gap is dropped and `overflowH` is set.
- Pop rules:
  - `popH`=1 with `gapValidH`=1 removes the head entry.
  - `popH` while empty is ignored.
- Simultaneous push and pop:
  - When full: both take effect; occupancy stays FIFO_DEPTH; no overflow.
  - When empty: the pop is ignored and the push is stored.
- `eventCount`:
  - +1 per event, including events whose gap is dropped.
  - Saturates at 2^CNT_WIDTH-1.
- `clearH`=1:
  - Next state: `gapCnt`=0, `eventCount`=0, `overflowH`=0, FIFO empty.
  - `detectD` still tracks `detectAH`.
  - An event or pop in the same cycle is discarded.
- Priority: `resetH` > `clearH` > push/pop/count.
- FIFO implementation:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Occupancy counter 0..FIFO_DEPTH; `fifoFullH` and `gapValidH` are derived from it.
  - `gapOut` = buffer[read pointer] when not empty, else 0.

## Timing
- Reset: after an edge with `resetH`=1, all outputs are 0, the FIFO is empty, `detectD`=0 and `gapCnt`=0. Consequently, `detectAH` already high in the first post-reset cycle counts as an event with gap 0.
- Latency: if `detectAH` is first sampled high at edge N, then immediately after edge N:
  - `eventCount` is updated;
  - `gapValidH`=1 with the new entry at `gapOut` (if the FIFO was empty);
  - `fifoFullH` / `overflowH` are updated.
- Pop: `popH` is sampled at edge N; the next entry (or `gapValidH`=0) appears right after edge N. Back-to-back pops every cycle are supported.
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- Throughput: one push and one pop per cycle. The minimum event spacing is 2 cycles, since the edge detect needs a low cycle between events.

## Test plan
- **Reset:** hold `resetH`=1 for 2 cycles with `detectAH`=1 -> all outputs 0. Release with `detectAH` still 1 -> `eventCount`=1, `gapOut`=0, `gapValidH`=1.
- **Spacing:** single-cycle pulses at post-reset cycles 10, 17, 24, then three pops -> `gapOut` reads 10, 7, 7; `eventCount`=3; `gapValidH`=0 after the third pop.
- **Level hold:** `detectAH` high for 5 cycles -> `eventCount`+1, one FIFO entry.
- **Overflow:** 5 events spaced 3 cycles, no pops -> `fifoFullH`=1 after the 4th; `overflowH`=1 after the 5th; `eventCount`=5; pops return the first four gaps only. Then `clearH` -> `overflowH`=0, `eventCount`=0, FIFO empty.
- **Full plus simultaneous:** FIFO full, event with `popH`=1 in the same cycle -> `overflowH` stays 0, `fifoFullH` stays 1, old head removed, new gap at the tail.
- **Saturation:** no event for 300 cycles, then a pulse -> `gapOut`=255. 257 events with `CNT_WIDTH`=8 -> `eventCount`=255.

Source files
------------

// File: rtl/sequence_event_logger.sv
// rtl/sequence_event_logger.sv - logs inter-detection gaps into a show-ahead FIFO
// Also keeps a saturating event count and a sticky overflow flag.
module sequence_event_logger #(
  parameter int GAP_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 sysClk,
  input  logic                 resetH,
  input  logic                 detectAH,
  input  logic                 clearH,
  input  logic                 popH,
  output logic [GAP_WIDTH-1:0] gapOut,
  output logic                 gapValidH,
  output logic                 fifoFullH,
  output logic                 overflowH,
  output logic [CNT_WIDTH-1:0] eventCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  logic                 detect_d;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic [GAP_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [OCC_W-1:0]     occ;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] event_cnt;

  logic event_hit;
  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_push;

  assign event_hit = detectAH & ~detect_d;
  assign is_empty  = (occ == '0);
  assign is_full   = (occ == FULL_OCC);
  assign do_pop    = popH & ~is_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push   = event_hit & (~is_full | do_pop);

  always_ff @(posedge sysClk) begin
    if (resetH) begin
      detect_d  <= 1'b0;
      gap_cnt   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      overflow  <= 1'b0;
      event_cnt <= '0;
    end else begin
      detect_d <= detectAH;
      if (clearH) begin
        gap_cnt   <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        occ       <= '0;
        overflow  <= 1'b0;
        event_cnt <= '0;
      end else begin
        if (event_hit) begin
          gap_cnt <= GAP_WIDTH'(1);
        end else if (gap_cnt != '1) begin
          gap_cnt <= gap_cnt + GAP_WIDTH'(1);
        end
        if (do_push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
        if (event_hit & ~do_push) begin
          overflow <= 1'b1;
        end
        if (event_hit && event_cnt != '1) begin
          event_cnt <= event_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (!resetH && !clearH && do_push) begin
      mem[wr_ptr] <= gap_cnt;
    end
  end

  assign gapOut     = is_empty ? '0 : mem[rd_ptr];
  assign gapValidH  = ~is_empty;
  assign fifoFullH  = is_full;
  assign overflowH  = overflow;
  assign eventCount = event_cnt;

endmodule

// File: tb/tb_sequence_event_logger.sv
// tb/tb_sequence_event_logger.sv - queue-model bench for sequence_event_logger
// Directed scenarios with literal expectations, then randomized traffic.
module tb_sequence_event_logger;

  localparam int DEPTH = 4;
  localparam int GMAX  = 255;
  localparam int CMAX  = 255;

  logic       sysClk;
  logic       resetH;
  logic       detectAH;
  logic       clearH;
  logic       popH;
  logic [7:0] gapOut;
  logic       gapValidH;
  logic       fifoFullH;
  logic       overflowH;
  logic [7:0] eventCount;

  sequence_event_logger #(.GAP_WIDTH(8), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .sysClk(sysClk), .resetH(resetH), .detectAH(detectAH), .clearH(clearH),
    .popH(popH), .gapOut(gapOut), .gapValidH(gapValidH), .fifoFullH(fifoFullH),
    .overflowH(overflowH), .eventCount(eventCount)
  );

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  // Model: a gap is simply the number of edges since the previous event (or reset/clear).
  int m_q[$];
  bit m_prev;
  bit m_ovf;
  int m_cnt;
  int m_since;

  always @(posedge sysClk) begin
    bit ev;
    int gap;
    if (resetH) begin
      m_q.delete();
      m_prev  = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
      m_since = 0;
    end else begin
      ev     = detectAH && !m_prev;
      m_prev = detectAH;
      if (clearH) begin
        m_q.delete();
        m_ovf   = 1'b0;
        m_cnt   = 0;
        m_since = 0;
      end else begin
        gap = (m_since > GMAX) ? GMAX : m_since;
        if (popH && m_q.size() > 0) void'(m_q.pop_front());
        if (ev) begin
          if (m_cnt < CMAX) m_cnt++;
          if (m_q.size() < DEPTH) m_q.push_back(gap);
          else m_ovf = 1'b1;
        end
        if (ev) m_since = 1;
        else if (m_since < 100000) m_since++;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("valid", int'(gapValidH), (m_q.size() > 0) ? 1 : 0);
    chk("gap", int'(gapOut), (m_q.size() > 0) ? m_q[0] : 0);
    chk("full", int'(fifoFullH), (m_q.size() == DEPTH) ? 1 : 0);
    chk("overflow", int'(overflowH), int'(m_ovf));
    chk("count", int'(eventCount), m_cnt);
  endtask

  task automatic step(input bit r, input bit d, input bit p, input bit c);
    resetH   = r;
    detectAH = d;
    popH     = p;
    clearH   = c;
    @(posedge sysClk);
    #1;
    compare_model();
  endtask

  initial begin
    resetH = 1'b1; detectAH = 1'b1; popH = 1'b0; clearH = 1'b0;

    // Reset with detect held high, then release.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_count", int'(eventCount), 0);
    chk("rst_valid", int'(gapValidH), 0);
    chk("rst_gap", int'(gapOut), 0);
    chk("rst_full", int'(fifoFullH), 0);
    chk("rst_ovf", int'(overflowH), 0);
    step(0, 1, 0, 0);
    chk("post_rst_count", int'(eventCount), 1);
    chk("post_rst_valid", int'(gapValidH), 1);
    chk("post_rst_gap", int'(gapOut), 0);
    step(0, 0, 1, 0);
    chk("post_rst_pop", int'(gapValidH), 0);

    // Pulses at post-reset edges 10, 17, 24.
    step(1, 0, 0, 0);
    for (int e = 0; e <= 24; e++) step(0, (e == 10 || e == 17 || e == 24), 0, 0);
    chk("sp_count", int'(eventCount), 3);
    chk("sp_gap0", int'(gapOut), 10);
    step(0, 0, 1, 0);
    chk("sp_gap1", int'(gapOut), 7);
    step(0, 0, 1, 0);
    chk("sp_gap2", int'(gapOut), 7);
    step(0, 0, 1, 0);
    chk("sp_empty", int'(gapValidH), 0);

    // Level held five cycles is a single event.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("lvl_count", int'(eventCount), 4);
    chk("lvl_valid", int'(gapValidH), 1);
    chk("lvl_full", int'(fifoFullH), 0);
    step(0, 0, 1, 0);
    chk("lvl_one_entry", int'(gapValidH), 0);

    // Overflow: events at post-clear edges 0,3,6,9,12 push 0,3,3,3 and drop one.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      if (i == 3) begin
        chk("ov_full4", int'(fifoFullH), 1);
        chk("ov_ovf4", int'(overflowH), 0);
      end
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    chk("ov_ovf5", int'(overflowH), 1);
    chk("ov_count", int'(eventCount), 5);
    for (int i = 0; i < 4; i++) begin
      chk("ov_drain", int'(gapOut), (i == 0) ? 0 : 3);
      step(0, 0, 1, 0);
    end
    chk("ov_drained", int'(gapValidH), 0);
    chk("ov_sticky", int'(overflowH), 1);
    step(0, 0, 0, 1);
    chk("clr_ovf", int'(overflowH), 0);
    chk("clr_count", int'(eventCount), 0);
    chk("clr_valid", int'(gapValidH), 0);

    // Full FIFO plus push and pop together.
    for (int e = 0; e <= 11; e++)
      step(0, (e == 0 || e == 2 || e == 4 || e == 6 || e == 11), (e == 11), 0);
    chk("fs_full", int'(fifoFullH), 1);
    chk("fs_ovf", int'(overflowH), 0);
    chk("fs_count", int'(eventCount), 5);
    chk("fs_head", int'(gapOut), 2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("fs_tail", int'(gapOut), 5);
    step(0, 0, 1, 0);

    // Gap and count saturation.
    step(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("sat_gap", int'(gapOut), 255);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 257; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      if (i == 253) chk("sat_count254", int'(eventCount), 254);
    end
    chk("sat_count", int'(eventCount), 255);
    chk("sat_ovf", int'(overflowH), 1);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
